// File: rtl/sdrc_wb_arbiter_if.sv
// Wishbone bundle between NUM_M application masters and the arbiter,
// plus the single downstream port toward the SDRAM controller.
interface sdrc_wb_arbiter_if #(
  parameter int NUM_M  = 2,
  parameter int APP_AW = 26,
  parameter int DW     = 32,
  parameter int BW     = 4
);
  logic [NUM_M-1:0]        m_cyc_i;
  logic [NUM_M-1:0]        m_stb_i;
  logic [NUM_M-1:0]        m_we_i;
  logic [NUM_M*APP_AW-1:0] m_addr_i;
  logic [NUM_M*DW-1:0]     m_dat_i;
  logic [NUM_M*BW-1:0]     m_sel_i;
  logic [NUM_M*3-1:0]      m_cti_i;
  logic [NUM_M-1:0]        m_ack_o;
  logic [DW-1:0]           m_dat_o;

  logic                    wb_cyc_o;
  logic                    wb_stb_o;
  logic                    wb_we_o;
  logic [APP_AW-1:0]       wb_addr_o;
  logic [DW-1:0]           wb_dat_o;
  logic [BW-1:0]           wb_sel_o;
  logic [2:0]              wb_cti_o;
  logic                    wb_ack_i;
  logic [DW-1:0]           wb_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i,
    input  m_addr_i, m_dat_i, m_sel_i, m_cti_i,
    output m_ack_o, m_dat_o,
    output wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_ack_i, wb_dat_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i,
    output m_addr_i, m_dat_i, m_sel_i, m_cti_i,
    input  m_ack_o, m_dat_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/sdrc_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of sdrc_top; grant held per cycle.
// Optional ownership watchdog enabled by defining ARB_WDOG_EN.
module sdrc_wb_arbiter #(
  parameter int NUM_M    = 2,
  parameter int APP_AW   = 26,
  parameter int DW       = 32,
  parameter int BW       = 4,
  parameter int WDOG_CYC = 255
) (
  input  logic             sys_clk,
  input  logic             resetn,
  input  logic             sdr_init_done,
  sdrc_wb_arbiter_if.slave bus,
  output logic [NUM_M-1:0] grant_o,
  output logic             wdog_flag_o
);

  localparam int PW = (NUM_M > 2) ? 2 : 1;

  typedef enum logic {IDLE, OWN} state_e;

  state_e           state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [PW-1:0]    gidx_q, gidx_d;
  logic [PW-1:0]    last_q, last_d;
  logic [PW-1:0]    pick;
  logic             found;
  logic             own;
  logic             rel;
  logic             wdog_hit;

  assign own = (state_q == OWN);

  // Search starts one past the previous owner and wraps.
  always_comb begin : rr_search
    int          kk;
    logic [PW-1:0] idx;
    found = 1'b0;
    pick  = '0;
    kk    = 0;
    idx   = '0;
    for (int i = 1; i <= NUM_M; i++) begin
      kk  = (int'(last_q) + i) % NUM_M;
      idx = PW'(kk);
      if (!found && bus.m_cyc_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign rel = own && (!bus.m_cyc_i[gidx_q] || wdog_hit);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (sdr_init_done && found) begin
          state_d = OWN;
          grant_d = NUM_M'(1) << pick;
          gidx_d  = pick;
        end
      end
      OWN: begin
        if (rel) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= PW'(NUM_M - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

  assign grant_o = grant_q;

  assign bus.wb_cyc_o  = own & bus.m_cyc_i[gidx_q];
  assign bus.wb_stb_o  = own & bus.m_stb_i[gidx_q];
  assign bus.wb_we_o   = own & bus.m_we_i[gidx_q];
  assign bus.wb_addr_o = own ? bus.m_addr_i[gidx_q*APP_AW +: APP_AW] : '0;
  assign bus.wb_dat_o  = own ? bus.m_dat_i[gidx_q*DW +: DW] : '0;
  assign bus.wb_sel_o  = own ? bus.m_sel_i[gidx_q*BW +: BW] : '0;
  assign bus.wb_cti_o  = own ? bus.m_cti_i[gidx_q*3 +: 3] : '0;

  assign bus.m_ack_o = grant_q & {NUM_M{bus.wb_ack_i}};
  assign bus.m_dat_o = bus.wb_dat_i;

`ifdef ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYC + 1);

  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          wflag_q;

  always_comb begin
    wcnt_d = wcnt_q;
    if (!own || bus.wb_ack_i)
      wcnt_d = '0;
    else if (bus.wb_stb_o)
      wcnt_d = wcnt_q + 1'b1;
  end

  // Fires on the last stalled strobe cycle so release lands on that edge.
  assign wdog_hit = own && bus.wb_stb_o && !bus.wb_ack_i &&
                    (wcnt_q == CW'(WDOG_CYC - 1));

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      wcnt_q  <= '0;
      wflag_q <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      wflag_q <= wflag_q | wdog_hit;
    end
  end

  assign wdog_flag_o = wflag_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYC;
  assign wdog_hit    = 1'b0;
  assign wdog_flag_o = 1'b0;
`endif

endmodule

// File: doc/sdrc_wb_arbiter.md
Name: sdrc_wb_arbiter

Overview:
- Round-robin Wishbone arbiter that shares the single sdrc_top Wishbone slave port between NUM_M masters.
- Sits between application masters (CPU, DMA, test agents) and the SDRAM controller, in the sys_clk domain.
- Holds a grant for a whole Wishbone cycle (cyc high), including incrementing bursts.
- Blocks all grants until the SDRAM controller reports init done.

Parameters:
- NUM_M, 2, number of masters (legal 2..4).
- APP_AW, 26, application address width.
- DW, 32, Wishbone data width.
- BW, 4, byte-select width (DW/8).
- WDOG_CYC, 255, watchdog limit in cycles (used only with ARB_WDOG_EN).

Ports:
- sys_clk  in  1  system clock; all logic is rising-edge.
- resetn  in  1  reset, asynchronous, active-low.
- sdr_init_done  in  1  SDRAM init complete; no grant is issued while this is low.
- m_cyc_i  in  NUM_M  per-master cycle.
- m_stb_i  in  NUM_M  per-master strobe.
- m_we_i  in  NUM_M  per-master write enable.
- m_addr_i  in  NUM_M*APP_AW  packed per-master addresses; master k is at [k*APP_AW +: APP_AW].
- m_dat_i  in  NUM_M*DW  packed per-master write data.
- m_sel_i  in  NUM_M*BW  packed per-master byte selects.
- m_cti_i  in  NUM_M*3  packed per-master cycle type.
- m_ack_o  out  NUM_M  per-master acknowledge.
- m_dat_o  out  DW  read data, broadcast to all masters.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  to the controller.
- wb_addr_o  out  APP_AW  to the controller.
- wb_dat_o  out  DW  to the controller.
- wb_sel_o  out  BW  to the controller.
- wb_cti_o  out  3  to the controller.
- wb_ack_i  in  1  from the controller.
- wb_dat_i  in  DW  from the controller.
- grant_o  out  NUM_M  one-hot registered grant (all zero when idle).
- wdog_flag_o  out  1  sticky watchdog event.

Behaviour:
- Reset values (async, resetn low):
  - grant_o=0, state=IDLE, last_ptr=NUM_M-1 (so master 0 wins first), wdog_flag_o=0.
  - All wb_*_o are 0 because the slave mux is gated by grant.
- States: IDLE, OWN.
- IDLE transitions:
  - If sdr_init_done=1 and any m_cyc_i=1, choose the first requesting master searching from last_ptr+1 upward with wrap mod NUM_M.
  - Register the one-hot grant and go to OWN.
  - Otherwise stay in IDLE.
- Latency: a request seen at edge t makes grant_o valid and wb_cyc_o high from cycle t+1. A sole requester therefore waits exactly 1 cycle.
- OWN datapath:
  - wb_*_o are a combinational mux of the granted master's signals.
  - m_ack_o[g] = wb_ack_i & grant_o[g]; ungranted m_ack_o are 0.
  - m_dat_o = wb_dat_i, unconditionally.
- Ownership is held while m_cyc_i[g]=1, even if stb drops (locked cycle).
- OWN exit:
  - When the granted m_cyc_i falls, wb_cyc_o falls in the same cycle.
  - Next edge: clear the grant, set last_ptr=g, go to IDLE.
  - wb_cyc_o is therefore low for at least 1 cycle between owners.
- Grant changes only at the OWN->IDLE and IDLE->OWN transitions. Never switch mid-burst.
- Simultaneous requests in IDLE: the round-robin order decides, each requester wins at most once per rotation.
- Owner drops cyc while another master raises it in the same cycle: go IDLE first, then arbitrate normally.
- sdr_init_done falling during OWN: the current cycle completes; no new grant until it returns high.
- Reset asserted mid-cycle: outputs drop immediately (async); no ack is generated afterwards.
- Requests from ungranted masters are never acked and never reach the slave.

Optional Feature:
- Macro: ARB_WDOG_EN.
- With the macro:
  - A counter resets on every grant and every wb_ack_i, and increments in OWN while wb_stb_o=1 and wb_ack_i=0.
  - When it reaches WDOG_CYC: force OWN->IDLE (grant cleared, wb_cyc_o low next cycle), set wdog_flag_o=1 (sticky until reset), and advance last_ptr past the stuck master.
- Without the macro: no counter; wdog_flag_o is tied 0 and ownership is unbounded.

Test Plan:
- Single write: init done, master0 cyc/stb/we, addr 0x000_0040, data 0xA5A5_5A5A, sel 0xF, cti 3'b000 -> wb_cyc_o high 1 cycle after request, slave sees exact addr/data/sel, m_ack_o[0] mirrors wb_ack_i, grant_o returns to 0 after cyc drops.
- Contention: masters 0 and 1 request the same cycle, each doing 4 single writes back-to-back -> grants alternate 01,10,01,10..., with ≥1 idle cycle of wb_cyc_o between owners.
- Burst hold: master1 does 8-beat incrementing burst (cti 3'b010, last 3'b111) while master0 requests -> grant stays 10 for all 8 acks; master0 is granted only after master1 cyc falls.
- Init gating: sdr_init_done=0 and master0 requests for 20 cycles -> wb_cyc_o stays 0, no ack; raise init done -> grant on the next edge.
- Reset mid-burst: assert resetn=0 on beat 3 of a 4-beat read -> all wb_*_o and grant_o are 0 immediately; after release, master0 wins first.
- ARB_WDOG_EN with WDOG_CYC=16: slave never acks -> at cycle 16 of stb grant is released, wdog_flag_o=1, and the waiting master1 is granted next.
